// File: rtl/rv_mem_pkg.sv
// Shared types and codes for the unified memory port.
// funct3 size codes, sequencer states and the alignment rule.
package rv_mem_pkg;

  localparam int LANES = 4;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_FAULT
  } state_e;

  // True when the access size cannot be issued at this byte offset
  function automatic logic f3_fault(
    input logic [2:0] f,
    input logic [1:0] a
  );
    logic flt;
    unique case (f)
      F3_B, F3_BU: flt = 1'b0;
      F3_H, F3_HU: flt = a[0];
      F3_W:        flt = (a != 2'b00);
      default:     flt = 1'b1;
    endcase
    return flt;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
// Purely combinational; driven from the latched access.
module mem_lane_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  f3_i,
  input  logic [1:0]  ofs_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mrdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = mrdata_i[8*ofs_i +: 8];
  assign half_sel = ofs_i[1] ? mrdata_i[31:16] : mrdata_i[15:0];

  // Decode size code into lane enables, replicated data and extended load
  always_comb begin
    be_o    = 4'hF;
    wdata_o = wdata_i;
    rdata_o = mrdata_i;
    unique case (f3_i)
      F3_B: begin
        be_o    = 4'b0001 << ofs_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_BU: begin
        be_o    = 4'b0001 << ofs_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, byte_sel};
      end
      F3_H: begin
        be_o    = 4'b0011 << ofs_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{half_sel[15]}}, half_sel};
      end
      F3_HU: begin
        be_o    = 4'b0011 << ofs_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, half_sel};
      end
      default: begin
        be_o    = 4'hF;
        wdata_o = wdata_i;
        rdata_o = mrdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory access sequencer for the multi-cycle datapath.
// Latches one request, runs req/ack, reports done/fault.
module mem_port_ctrl
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        f3,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              misalign,
  output logic              bus_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_be,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic              tmo_q, tmo_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wd;
  logic [DATA_W-1:0] ld_data;
  logic              in_req;
  logic              any_req;

  mem_lane_align u_align (
    .f3_i     (f3_q),
    .ofs_i    (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .mrdata_i (m_rdata),
    .be_o     (st_be),
    .wdata_o  (st_wd),
    .rdata_o  (ld_data)
  );

  assign any_req = req_rd | req_wr;
  assign in_req  = (state_q == S_REQ);

  // State and latched access registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: accept, wait for ack or timeout, then report
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    we_d    = we_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          addr_d  = addr;
          wdata_d = wdata;
          f3_d    = f3;
          we_d    = req_wr;
          if (f3_fault(f3, addr[1:0])) begin
            state_d = S_FAULT;
            tmo_d   = 1'b0;
          end else begin
            state_d = S_REQ;
            cnt_d   = '0;
          end
        end
      end
      S_REQ: begin
        if (m_ack) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = ld_data;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_FAULT;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus drive is gated to REQ so nothing leaks while idle
  always_comb begin
    m_req    = in_req;
    m_we     = in_req & we_q;
    m_addr   = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    m_be     = in_req ? (we_q ? st_be : 4'hF) : 4'h0;
    m_wdata  = (in_req & we_q) ? st_wd : '0;
    done     = (state_q == S_DONE) | (state_q == S_FAULT);
    misalign = (state_q == S_FAULT) & ~tmo_q;
    bus_err  = (state_q == S_FAULT) & tmo_q;
    busy     = ((state_q == S_IDLE) & any_req) | in_req;
    rdata    = rdata_q;
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a completion scoreboard.
// Driver plays controller and memory; monitor checks each done.
module tb_mem_port_ctrl;

  typedef struct {
    logic        mis;
    logic        berr;
    logic [31:0] rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  f3 = '0;
  logic [31:0] rdata;
  logic        busy, done, misalign, bus_err;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = '0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  mem_port_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_rd   (req_rd),
    .req_wr   (req_wr),
    .addr     (addr),
    .wdata    (wdata),
    .f3       (f3),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .misalign (misalign),
    .bus_err  (bus_err),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
    .m_ack    (m_ack),
    .m_rdata  (m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: every completion pulse is matched against the queue
  always @(negedge clk) begin
    #1;
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done act=1 exp=0");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_misalign", 32'(misalign), 32'(e.mis));
        chk("sb_bus_err", 32'(bus_err), 32'(e.berr));
        chk("sb_rdata", rdata, e.rd);
      end
    end
  end

  // One controller transaction; waits<0 means memory never acks
  task automatic access(
    input bit rd, input bit wr,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [2:0] f, input int waits,
    input logic [31:0] mrd,
    input bit ex_mis, input bit ex_berr,
    input logic [3:0] ex_be, input logic [31:0] ex_wd,
    input logic [31:0] ex_rd
  );
    int   nreq, nbusy, lat, ex_nreq;
    bit   seen;
    exp_t e;
    ex_nreq = ex_mis ? 0 : (ex_berr ? 16 : waits + 1);
    e.mis = ex_mis;
    e.berr = ex_berr;
    e.rd = ex_rd;
    sb_q.push_back(e);
    nreq = 0;
    nbusy = 0;
    lat = -1;
    seen = 1'b0;
    @(negedge clk);
    req_rd = rd;
    req_wr = wr;
    addr = a;
    wdata = wd;
    f3 = f;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (busy) nbusy++;
      if (done) begin
        lat = c;
        seen = 1'b1;
        break;
      end
      if (m_req) begin
        chk("m_addr", m_addr, {a[31:2], 2'b00});
        chk("m_be", 32'(m_be), 32'(ex_be));
        chk("m_we", 32'(m_we), 32'(wr));
        if (wr) chk("m_wdata", m_wdata, ex_wd);
        if (nreq == waits) begin
          m_ack = 1'b1;
          m_rdata = mrd;
        end
        nreq++;
      end
      @(negedge clk);
      m_ack = 1'b0;
      m_rdata = 32'h5A5A_5A5A;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout act=0 exp=1");
    end
    chk("req_cycles", 32'(nreq), 32'(ex_nreq));
    chk("latency", 32'(lat), 32'(ex_nreq + 1));
    chk("busy_cycles", 32'(nbusy), 32'(ex_nreq + 1));
    @(negedge clk);
    #1;
    chk("post_done_idle", {30'h0, m_req, done}, 32'h0);
    req_rd = 1'b0;
    req_wr = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_m_req"}, 32'(m_req), 32'h0);
    chk({nm, "_m_we"}, 32'(m_we), 32'h0);
    chk({nm, "_m_addr"}, m_addr, 32'h0);
    chk({nm, "_m_wdata"}, m_wdata, 32'h0);
    chk({nm, "_m_be"}, 32'(m_be), 32'h0);
    chk({nm, "_rdata"}, rdata, 32'h0);
    chk({nm, "_flags"}, {28'h0, busy, done, misalign, bus_err}, 32'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    access(1, 0, 32'h100, 32'h0, 3'd2, 0, 32'hDEADBEEF,
           0, 0, 4'hF, 32'h0, 32'hDEADBEEF);
    access(0, 1, 32'h203, 32'hA5, 3'd0, 3, 32'h0,
           0, 0, 4'b1000, 32'hA5A5A5A5, 32'hDEADBEEF);
    access(1, 0, 32'h102, 32'h0, 3'd0, 0, 32'h0080FF00,
           0, 0, 4'hF, 32'h0, 32'hFFFFFF80);
    access(1, 0, 32'h102, 32'h0, 3'd4, 1, 32'h0080FF00,
           0, 0, 4'hF, 32'h0, 32'h00000080);
    access(1, 0, 32'h102, 32'h0, 3'd5, 0, 32'h0080FF00,
           0, 0, 4'hF, 32'h0, 32'h00000080);
    access(1, 0, 32'h100, 32'h0, 3'd1, 0, 32'h0080FF00,
           0, 0, 4'hF, 32'h0, 32'hFFFFFF00);
    access(0, 1, 32'h101, 32'h1234, 3'd1, 0, 32'h0,
           1, 0, 4'h0, 32'h0, 32'hFFFFFF00);
    access(1, 0, 32'h102, 32'h0, 3'd2, 0, 32'h11111111,
           1, 0, 4'h0, 32'h0, 32'hFFFFFF00);
    access(1, 0, 32'h100, 32'h0, 3'd3, 0, 32'h11111111,
           1, 0, 4'h0, 32'h0, 32'hFFFFFF00);
    access(1, 0, 32'h104, 32'h0, 3'd2, -1, 32'h0,
           0, 1, 4'hF, 32'h0, 32'hFFFFFF00);
    access(0, 1, 32'h302, 32'h1234ABCD, 3'd1, 1, 32'h0,
           0, 0, 4'b1100, 32'hABCDABCD, 32'hFFFFFF00);
    access(1, 1, 32'h300, 32'h11223344, 3'd2, 0, 32'hCAFEF00D,
           0, 0, 4'hF, 32'h11223344, 32'hFFFFFF00);
    access(1, 0, 32'h300, 32'h0, 3'd2, 2, 32'h11223344,
           0, 0, 4'hF, 32'h0, 32'h11223344);

    @(negedge clk);
    req_rd = 1'b1;
    addr = 32'h100;
    f3 = 3'd2;
    @(negedge clk);
    #1;
    chk("rst_pre_m_req", 32'(m_req), 32'h1);
    rst = 1'b1;
    req_rd = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;

    access(1, 0, 32'h208, 32'h0, 3'd2, 0, 32'h0BADF00D,
           0, 0, 4'hF, 32'h0, 32'h0BADF00D);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
- Memory access sequencer between the multi-cycle RISC-V datapath's unified memory port (instruction fetch, load and store) and an external word-wide memory with req/ack handshake.
- Handles byte-lane steering for sb/sh/sw and load extension for lb/lh/lw/lbu/lhu.
- Detects misaligned accesses and bus timeouts.
- Asserts busy so the main controller FSM holds its state until the access completes.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, 4 byte lanes.
- TIMEOUT, 16, cycles in REQ without m_ack before bus error; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_rd  in  1  read request from datapath (fetch or load), level
- req_wr  in  1  write request (controller memwrite), level
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  store data, unshifted (rs2)
- f3  in  3  access size/sign (funct3 encoding); datapath drives 3'b010 for fetch
- rdata  out  DATA_W  aligned, extended read data; held until next read completes
- busy  out  1  stall to controller
- done  out  1  one-cycle completion pulse
- misalign  out  1  pulses with done on an alignment or illegal-f3 fault
- bus_err  out  1  pulses with done on a timeout
- m_req  out  1  external request
- m_we  out  1  external write enable
- m_addr  out  ADDR_W  word-aligned address, addr[1:0] forced to 0
- m_wdata  out  DATA_W  lane-steered store data
- m_be  out  4  byte enables; 4'hF for reads
- m_ack  in  1  external acknowledge, one cycle
- m_rdata  in  DATA_W  external read data, valid with m_ack

Behaviour:
- Reset: state IDLE; all outputs 0, including rdata, m_addr, m_wdata, m_be and counter. Reset mid-access drops m_req immediately and discards the access.
- States: IDLE, REQ, DONE, FAULT.
- IDLE:
  - On req_rd|req_wr: latch addr, f3, wdata and we=req_wr.
  - If both requests are high, the write wins and the read is ignored.
  - Alignment check:
    - f3[1:0]=01 (halfword): fault if addr[0]=1.
    - f3[1:0]=10 (word): fault if addr[1:0]!=0.
    - f3 in {3,6,7}: illegal, fault.
    - Fault goes to FAULT; otherwise go to REQ and clear the counter.
- REQ:
  - m_req=1, with m_we, m_addr, m_wdata and m_be stable from latched values.
  - m_ack is sampled every REQ cycle, including the first.
  - On m_ack: if read, capture the extended m_rdata into rdata; go to DONE.
  - If no ack and counter==TIMEOUT-1: go to FAULT with the timeout cause; otherwise the counter increments.
- DONE: done=1 for one cycle; return to IDLE. Requests seen in this cycle are ignored, because they are the just-completed request still asserted by the controller.
- FAULT: done=1 and one of misalign/bus_err=1 for one cycle; rdata unchanged; no bus write occurred; return to IDLE.
- busy, combinational: (IDLE & (req_rd|req_wr)) | REQ. busy=0 in DONE, FAULT and idle-without-request.
- Latency: request cycle to done is 2 cycles with m_ack in the first REQ cycle, plus 1 cycle per wait state.
- m_ack outside REQ is ignored.
- Store steering, k=addr[1:0]:
  - sb: m_be=1<<k, byte replicated on all 4 lanes.
  - sh: m_be=3<<k, halfword replicated on both halves.
  - sw: m_be=4'hF.
- Load extraction:
  - lb/lbu: byte at lane k, sign-/zero-extended.
  - lh/lhu: half at lane k[1], sign-/zero-extended.
  - lw: full word.
- f3 decode: 0=b, 1=h, 2=w, 4=bu, 5=hu.

Decomposition:
- Shared package rv_mem_pkg: f3 size codes (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding, lane count.
- One combinational sub-module mem_lane_align: store byte-enable/data steering plus load extraction/extension, instanced once.
- Sequencing and counter stay in mem_port_ctrl.

Test Plan:
- lw, addr=0x100, m_ack in first REQ cycle, m_rdata=0xDEADBEEF -> m_addr=0x100, m_be=F, done in cycle 3, rdata=0xDEADBEEF, busy high for exactly 2 cycles.
- sb, addr=0x203, wdata=0x000000A5, ack after 3 wait cycles -> m_be=4'b1000, m_wdata=0xA5A5A5A5, m_we=1 stable throughout REQ, done after 5 cycles.
- lb, addr=0x102, m_rdata=0x0080FF00 -> rdata=0xFFFFFF80; lbu same -> 0x00000080; lhu addr=0x102 -> 0x00000080; lh addr=0x100 -> 0xFFFFFF00.
- sh addr=0x101 and lw addr=0x102 -> FAULT, misalign=1 with done, m_req never asserted, rdata unchanged.
- No m_ack with TIMEOUT=16 -> m_req high 16 cycles, then bus_err=1 with done; the next request proceeds normally.
- Assert rst during REQ -> m_req low without a clock edge, all outputs 0; req_rd and req_wr both high -> write performed, no read.
